cache_cell_controller: RTL and testbench
========================================

Name: cache_cell_controller

Overview:
- Sequencing controller for a bank of NUM_CELLS key/value/TTL memory cells.
- Accepts GET/SET/DEL commands over a valid/ready interface and scans the cells one per cycle for a key match or a free slot.
- Issues at most one one-hot cell write per command and returns a response over a valid/ready interface.
- Sits between the command front-end and the memory cell array; it is the only writer of the cells.

Parameters:
- NUM_CELLS, 8, number of cells managed (>=2); IDX_WIDTH = $clog2(NUM_CELLS) is a derived localparam.
- KEY_WIDTH, 64, key width.
- VALUE_WIDTH, 64, value width.
- TTL_WIDTH, 32, TTL width.

Ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  controller can accept a command; high only in IDLE.
- cmd_op  in  2  0=GET, 1=SET, 2=DEL, 3=reserved.
- cmd_key  in  KEY_WIDTH  command key.
- cmd_value  in  VALUE_WIDTH  SET value.
- cmd_ttl  in  TTL_WIDTH  SET TTL.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed.
- rsp_status  out  2  0=OK, 1=MISS, 2=FULL, 3=ERR.
- rsp_value  out  VALUE_WIDTH  GET hit value; 0 otherwise.
- busy  out  1  high in any state other than IDLE.
- cell_valid  in  NUM_CELLS  per-cell valid flags.
- cell_key_bus  in  NUM_CELLS*KEY_WIDTH  cell keys; cell i at [i*KEY_WIDTH +: KEY_WIDTH].
- cell_value_bus  in  NUM_CELLS*VALUE_WIDTH  cell values, same packing.
- cell_we  out  NUM_CELLS  one-hot cell write enable.
- cell_key_wr  out  KEY_WIDTH  write key, shared by all cells.
- cell_value_wr  out  VALUE_WIDTH  write value, shared.
- cell_ttl_wr  out  TTL_WIDTH  write TTL, shared.

Behaviour:
- Reset (async, immediate): state=IDLE; scan index=0.
  - Latched command and all tracking registers cleared.
  - cell_we=0, cell_*_wr=0, rsp_valid=0, rsp_status=0, rsp_value=0.
  - cmd_ready=1 after reset deasserts.
  - Reset mid-command drops the command; no write or response is produced.
- FSM states: IDLE, SCAN, WRITE, RESP.
- IDLE: accept on cmd_valid&&cmd_ready in cycle t; latch op, key, value and ttl.
  - op==3, or SET with cmd_ttl==0: go to RESP with ERR, rsp_valid at t+1, no scan.
  - Otherwise go to SCAN with idx=0.
- SCAN: cycles t+1..t+NUM_CELLS examine cell idx=0..NUM_CELLS-1, one per cycle.
  - Match: cell_valid[idx] && key==latched key. Record the lowest matching index only.
  - Free: !cell_valid[idx]. Record the lowest free index only.
  - Match and free are each sampled in the cycle the index is scanned; a cell that expires after being scanned is not revisited.
  - After idx==NUM_CELLS-1, resolve in cycle t+NUM_CELLS+1:
    - GET hit: RESP, OK; rsp_value = value captured from the matching cell in its scan cycle.
    - GET miss: RESP, MISS, value 0.
    - SET with match: WRITE to the match index.
    - SET with no match and a free slot: WRITE to the lowest free index.
    - SET with neither: RESP, FULL, no write.
    - DEL with match: WRITE to the match index, cell_ttl_wr=0, key/value = latched key / 0. The cell invalidates itself one cycle later.
    - DEL with no match: RESP, MISS.
- WRITE: exactly one cycle.
  - cell_we one-hot at the target index.
  - cell_key_wr, cell_value_wr and cell_ttl_wr valid in that same cycle; SET drives the latched key, value and ttl.
  - Next cycle: RESP with OK.
  - cell_we is 0 in every other state.
- RESP: rsp_valid=1; status and value stable until rsp_valid&&rsp_ready, then IDLE.
  - rsp_valid is registered and deasserts the cycle after the handshake.
  - cmd_ready stays 0 in this state; no command overlap.
- Latency from the accept cycle t (default build):
  - GET / no-write outcomes: rsp_valid at t+NUM_CELLS+1.
  - SET / DEL with write: cell_we at t+NUM_CELLS+1, rsp_valid at t+NUM_CELLS+2.
  - ERR: rsp_valid at t+1.
- Scan index is IDX_WIDTH bits. The scan terminates on the compare against NUM_CELLS-1, so it is correct for non-power-of-2 NUM_CELLS and the index never wraps into the next scan.

Optional Feature:
- Macro: CACHE_CTRL_EARLY_EXIT_EN.
- Defined: on the first match, SCAN resolves in the following cycle without scanning the remaining cells.
  - Match at index k gives rsp_valid at t+k+2 (GET/DEL miss-free paths) or cell_we at t+k+2 (SET/DEL writes).
  - Miss and free-slot paths still scan all cells.
- Undefined: latency is fixed as above, independent of hit position.

Test Plan:
- NUM_CELLS=4, all cells invalid; SET key=0xA5, value=0x1234, ttl=10 -> cell_we=4'b0001 at t+5 with cell_ttl_wr=10; rsp OK at t+6.
- Cell 2 valid with key=0xA5, value=0x77; GET 0xA5 -> rsp OK, rsp_value=0x77 at t+5; GET 0xB0 -> MISS, value 0.
- All 4 cells valid with distinct keys; SET new key -> FULL, cell_we never asserted; SET an existing key in cell 3 -> cell_we=4'b1000 (TTL refresh).
- DEL a key held in cell 1 -> cell_we=4'b0010 with ttl 0, then OK; DEL an absent key -> MISS; cmd_op=3 or SET ttl=0 -> ERR at t+1.
- Hold rsp_ready=0 for 5 cycles -> rsp_valid, status and value stable, cmd_ready=0; rst pulsed mid-SCAN -> IDLE, no cell_we, no response.
- With CACHE_CTRL_EARLY_EXIT_EN, GET hit in cell 0 -> rsp_valid at t+2; without the macro -> t+5.

Source files
------------

// File: rtl/cache_cell_controller.sv
// Command sequencer for a bank of key/value/TTL cells: scans one cell per cycle, issues one write, returns a response.
// Optional macro CACHE_CTRL_EARLY_EXIT_EN resolves the scan on the first key match.
module cache_cell_controller #(
  parameter int NUM_CELLS   = 8,
  parameter int KEY_WIDTH   = 64,
  parameter int VALUE_WIDTH = 64,
  parameter int TTL_WIDTH   = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [1:0]                       cmd_op,
  input  logic [KEY_WIDTH-1:0]             cmd_key,
  input  logic [VALUE_WIDTH-1:0]           cmd_value,
  input  logic [TTL_WIDTH-1:0]             cmd_ttl,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [1:0]                       rsp_status,
  output logic [VALUE_WIDTH-1:0]           rsp_value,
  output logic                             busy,
  input  logic [NUM_CELLS-1:0]             cell_valid,
  input  logic [NUM_CELLS*KEY_WIDTH-1:0]   cell_key_bus,
  input  logic [NUM_CELLS*VALUE_WIDTH-1:0] cell_value_bus,
  output logic [NUM_CELLS-1:0]             cell_we,
  output logic [KEY_WIDTH-1:0]             cell_key_wr,
  output logic [VALUE_WIDTH-1:0]           cell_value_wr,
  output logic [TTL_WIDTH-1:0]             cell_ttl_wr
);

  localparam int IDX_WIDTH = $clog2(NUM_CELLS);

  localparam logic [1:0] OP_GET = 2'd0;
  localparam logic [1:0] OP_SET = 2'd1;
  localparam logic [1:0] OP_DEL = 2'd2;
  localparam logic [1:0] OP_RSV = 2'd3;

  localparam logic [1:0] ST_OK   = 2'd0;
  localparam logic [1:0] ST_MISS = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WRITE, S_RESP} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic [1:0]             r_op;
  logic [KEY_WIDTH-1:0]   r_key;
  logic [VALUE_WIDTH-1:0] r_value;
  logic [TTL_WIDTH-1:0]   r_ttl;
  logic [IDX_WIDTH-1:0]   r_idx;
  logic                   r_match_found;
  logic [IDX_WIDTH-1:0]   r_match_idx;
  logic [VALUE_WIDTH-1:0] r_match_value;
  logic                   r_free_found;
  logic [IDX_WIDTH-1:0]   r_free_idx;

  logic [NUM_CELLS-1:0]   r_we;
  logic [KEY_WIDTH-1:0]   r_key_wr;
  logic [VALUE_WIDTH-1:0] r_value_wr;
  logic [TTL_WIDTH-1:0]   r_ttl_wr;
  logic                   r_rsp_valid;
  logic [1:0]             r_rsp_status;
  logic [VALUE_WIDTH-1:0] r_rsp_value;

  logic [KEY_WIDTH-1:0]   w_cell_key   [NUM_CELLS];
  logic [VALUE_WIDTH-1:0] w_cell_value [NUM_CELLS];

  for (genvar g = 0; g < NUM_CELLS; g++) begin : g_unpack
    assign w_cell_key[g]   = cell_key_bus[g*KEY_WIDTH +: KEY_WIDTH];
    assign w_cell_value[g] = cell_value_bus[g*VALUE_WIDTH +: VALUE_WIDTH];
  end

  logic                   w_accept;
  logic                   w_bad_cmd;
  logic                   w_scan_hit;
  logic                   w_scan_free;
  logic                   w_match_found;
  logic [IDX_WIDTH-1:0]   w_match_idx;
  logic [VALUE_WIDTH-1:0] w_match_value;
  logic                   w_free_found;
  logic [IDX_WIDTH-1:0]   w_free_idx;
  logic [IDX_WIDTH-1:0]   w_tgt_idx;
  logic                   w_last;
  logic                   w_resolve;
  logic                   w_do_write;

  assign w_accept  = cmd_valid && (r_state == S_IDLE);
  assign w_bad_cmd = (cmd_op == OP_RSV) || ((cmd_op == OP_SET) && (cmd_ttl == '0));

  // Merge the current cell with earlier results so the lowest index wins.
  assign w_scan_hit    = cell_valid[r_idx] && (w_cell_key[r_idx] == r_key);
  assign w_scan_free   = !cell_valid[r_idx];
  assign w_match_found = r_match_found || w_scan_hit;
  assign w_match_idx   = r_match_found ? r_match_idx : r_idx;
  assign w_match_value = r_match_found ? r_match_value : w_cell_value[r_idx];
  assign w_free_found  = r_free_found || w_scan_free;
  assign w_free_idx    = r_free_found ? r_free_idx : r_idx;
  assign w_tgt_idx     = w_match_found ? w_match_idx : w_free_idx;
  assign w_last        = (r_idx == IDX_WIDTH'(NUM_CELLS - 1));

`ifdef CACHE_CTRL_EARLY_EXIT_EN
  assign w_resolve = w_last || w_scan_hit;
`else
  assign w_resolve = w_last;
`endif

  assign w_do_write = ((r_op == OP_SET) && (w_match_found || w_free_found)) ||
                      ((r_op == OP_DEL) && w_match_found);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_bad_cmd ? S_RESP : S_SCAN;
      S_SCAN:  if (w_resolve) w_state_nxt = w_do_write ? S_WRITE : S_RESP;
      S_WRITE: w_state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  logic [NUM_CELLS-1:0]   w_we_nxt;
  logic [KEY_WIDTH-1:0]   w_key_wr_nxt;
  logic [VALUE_WIDTH-1:0] w_value_wr_nxt;
  logic [TTL_WIDTH-1:0]   w_ttl_wr_nxt;
  logic                   w_rsp_valid_nxt;
  logic [1:0]             w_rsp_status_nxt;
  logic [VALUE_WIDTH-1:0] w_rsp_value_nxt;

  // Outputs are registered, so this computes their values for the next cycle.
  always_comb begin
    w_we_nxt         = '0;
    w_key_wr_nxt     = '0;
    w_value_wr_nxt   = '0;
    w_ttl_wr_nxt     = '0;
    w_rsp_valid_nxt  = r_rsp_valid;
    w_rsp_status_nxt = r_rsp_status;
    w_rsp_value_nxt  = r_rsp_value;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_bad_cmd) begin
          w_rsp_valid_nxt  = 1'b1;
          w_rsp_status_nxt = ST_ERR;
          w_rsp_value_nxt  = '0;
        end
      end
      S_SCAN: begin
        if (w_resolve) begin
          if (w_do_write) begin
            w_we_nxt[w_tgt_idx] = 1'b1;
            w_key_wr_nxt        = r_key;
            w_value_wr_nxt      = (r_op == OP_SET) ? r_value : '0;
            w_ttl_wr_nxt        = (r_op == OP_SET) ? r_ttl : '0;
          end else begin
            w_rsp_valid_nxt = 1'b1;
            w_rsp_value_nxt = '0;
            if (r_op == OP_GET) begin
              w_rsp_status_nxt = w_match_found ? ST_OK : ST_MISS;
              if (w_match_found) w_rsp_value_nxt = w_match_value;
            end else if (r_op == OP_SET) begin
              w_rsp_status_nxt = ST_FULL;
            end else begin
              w_rsp_status_nxt = ST_MISS;
            end
          end
        end
      end
      S_WRITE: begin
        w_rsp_valid_nxt  = 1'b1;
        w_rsp_status_nxt = ST_OK;
        w_rsp_value_nxt  = '0;
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt  = 1'b0;
          w_rsp_status_nxt = '0;
          w_rsp_value_nxt  = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we         <= '0;
      r_key_wr     <= '0;
      r_value_wr   <= '0;
      r_ttl_wr     <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_status <= '0;
      r_rsp_value  <= '0;
    end else begin
      r_we         <= w_we_nxt;
      r_key_wr     <= w_key_wr_nxt;
      r_value_wr   <= w_value_wr_nxt;
      r_ttl_wr     <= w_ttl_wr_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_rsp_status <= w_rsp_status_nxt;
      r_rsp_value  <= w_rsp_value_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op          <= '0;
      r_key         <= '0;
      r_value       <= '0;
      r_ttl         <= '0;
      r_idx         <= '0;
      r_match_found <= 1'b0;
      r_match_idx   <= '0;
      r_match_value <= '0;
      r_free_found  <= 1'b0;
      r_free_idx    <= '0;
    end else if (w_accept) begin
      r_op          <= cmd_op;
      r_key         <= cmd_key;
      r_value       <= cmd_value;
      r_ttl         <= cmd_ttl;
      r_idx         <= '0;
      r_match_found <= 1'b0;
      r_match_idx   <= '0;
      r_match_value <= '0;
      r_free_found  <= 1'b0;
      r_free_idx    <= '0;
    end else if (r_state == S_SCAN) begin
      r_match_found <= w_match_found;
      r_match_idx   <= w_match_idx;
      r_match_value <= w_match_value;
      r_free_found  <= w_free_found;
      r_free_idx    <= w_free_idx;
      if (!w_resolve) r_idx <= r_idx + 1'b1;
    end
  end

  assign cmd_ready     = (r_state == S_IDLE);
  assign busy          = (r_state != S_IDLE);
  assign rsp_valid     = r_rsp_valid;
  assign rsp_status    = r_rsp_status;
  assign rsp_value     = r_rsp_value;
  assign cell_we       = r_we;
  assign cell_key_wr   = r_key_wr;
  assign cell_value_wr = r_value_wr;
  assign cell_ttl_wr   = r_ttl_wr;

endmodule

// File: tb/tb_cache_cell_controller.sv
// Directed bench for cache_cell_controller (4 cells) with a per-cycle reference model of outcomes and latencies.
module tb_cache_cell_controller;
  localparam int N  = 4;
  localparam int KW = 64;
  localparam int VW = 64;
  localparam int TW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [1:0]      cmd_op = '0;
  logic [KW-1:0]   cmd_key = '0;
  logic [VW-1:0]   cmd_value = '0;
  logic [TW-1:0]   cmd_ttl = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [1:0]      rsp_status;
  logic [VW-1:0]   rsp_value;
  logic            busy;
  logic [N-1:0]    cell_valid;
  logic [N*KW-1:0] cell_key_bus;
  logic [N*VW-1:0] cell_value_bus;
  logic [N-1:0]    cell_we;
  logic [KW-1:0]   cell_key_wr;
  logic [VW-1:0]   cell_value_wr;
  logic [TW-1:0]   cell_ttl_wr;

  logic            tb_valid [N];
  logic [KW-1:0]   tb_key   [N];
  logic [VW-1:0]   tb_val   [N];

  int   n_vec = 0;
  int   n_fail = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  always_comb begin
    cell_valid     = '0;
    cell_key_bus   = '0;
    cell_value_bus = '0;
    for (int i = 0; i < N; i++) begin
      cell_valid[i]                 = tb_valid[i];
      cell_key_bus[i*KW +: KW]      = tb_key[i];
      cell_value_bus[i*VW +: VW]    = tb_val[i];
    end
  end

  cache_cell_controller #(
    .NUM_CELLS(N), .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .TTL_WIDTH(TW)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_key(cmd_key), .cmd_value(cmd_value), .cmd_ttl(cmd_ttl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
    .rsp_value(rsp_value), .busy(busy),
    .cell_valid(cell_valid), .cell_key_bus(cell_key_bus), .cell_value_bus(cell_value_bus),
    .cell_we(cell_we), .cell_key_wr(cell_key_wr), .cell_value_wr(cell_value_wr),
    .cell_ttl_wr(cell_ttl_wr)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Expected outcome of one command; cycle numbers are relative to the accept cycle.
  typedef struct {
    int            we_cyc;
    logic [N-1:0]  we;
    logic [KW-1:0] wk;
    logic [VW-1:0] wv;
    logic [TW-1:0] wt;
    int            rsp_cyc;
    logic [1:0]    st;
    logic [VW-1:0] rv;
  } exp_t;

  function automatic exp_t model(input logic [1:0] op, input logic [KW-1:0] k,
                                 input logic [VW-1:0] v, input logic [TW-1:0] t);
    exp_t e;
    int   m = -1;
    int   f = -1;
    int   res;
    e.we_cyc = -1; e.we = '0; e.wk = '0; e.wv = '0; e.wt = '0; e.rv = '0;
    e.rsp_cyc = 1; e.st = 2'd3;
    if (op == 2'd3 || (op == 2'd1 && t == 0)) return e;
    for (int i = 0; i < N; i++) begin
      if (tb_valid[i] && tb_key[i] == k && m < 0) m = i;
      if (!tb_valid[i] && f < 0) f = i;
    end
    res = N + 1;
`ifdef CACHE_CTRL_EARLY_EXIT_EN
    if (m >= 0) res = m + 2;
`endif
    case (op)
      2'd0: begin
        e.rsp_cyc = res;
        e.st = (m >= 0) ? 2'd0 : 2'd1;
        if (m >= 0) e.rv = tb_val[m];
      end
      2'd1: begin
        if (m >= 0 || f >= 0) begin
          e.we_cyc = res; e.we = N'(1) << ((m >= 0) ? m : f);
          e.wk = k; e.wv = v; e.wt = t;
          e.rsp_cyc = res + 1; e.st = 2'd0;
        end else begin
          e.rsp_cyc = res; e.st = 2'd2;
        end
      end
      default: begin
        if (m >= 0) begin
          e.we_cyc = res; e.we = N'(1) << m; e.wk = k;
          e.rsp_cyc = res + 1; e.st = 2'd0;
        end else begin
          e.rsp_cyc = res; e.st = 2'd1;
        end
      end
    endcase
    return e;
  endfunction

  initial begin : monitor
    exp_t e;
    int   rel = 0;
    bit   active = 1'b0;
    bit   hs = 1'b0;
    forever begin
      @(posedge clk);
      if (rst) begin
        active = 1'b0; hs = 1'b0;
      end else if (active) begin
        if (rsp_valid && rsp_ready) hs = 1'b1;
      end else if (cmd_valid && cmd_ready) begin
        active = 1'b1; hs = 1'b0; rel = 0;
        e = model(cmd_op, cmd_key, cmd_value, cmd_ttl);
      end
      @(negedge clk);
      if (chk_en) begin
        if (!active) begin
          chk("idle_cell_we", cell_we, 0);
          chk("idle_rsp_valid", rsp_valid, 0);
          chk("idle_cmd_ready", cmd_ready, 1);
          chk("idle_busy", busy, 0);
        end else if (hs) begin
          chk("post_hs_rsp_valid", rsp_valid, 0);
          chk("post_hs_cmd_ready", cmd_ready, 1);
          chk("post_hs_cell_we", cell_we, 0);
          active = 1'b0;
        end else begin
          rel++;
          chk("cell_we", cell_we, (rel == e.we_cyc) ? e.we : '0);
          if (rel == e.we_cyc) begin
            chk("cell_key_wr", cell_key_wr, e.wk);
            chk("cell_value_wr", cell_value_wr, e.wv);
            chk("cell_ttl_wr", cell_ttl_wr, e.wt);
          end
          chk("rsp_valid", rsp_valid, (rel >= e.rsp_cyc) ? 1 : 0);
          if (rel >= e.rsp_cyc) begin
            chk("rsp_status", rsp_status, e.st);
            chk("rsp_value", rsp_value, e.rv);
          end
          chk("busy_cmd_ready", cmd_ready, 0);
          if (rel > 60) begin
            chk("monitor_timeout", 0, 1);
            active = 1'b0;
          end
        end
      end
    end
  end

  task automatic run(input logic [1:0] op, input logic [63:0] k, input logic [63:0] v,
                     input logic [31:0] t, input int hold, output int lat,
                     output logic [1:0] st, output logic [63:0] val, output logic [N-1:0] we);
    @(negedge clk);
    cmd_op = op; cmd_key = k; cmd_value = v; cmd_ttl = t; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; lat = 1; we = '0;
    while (!rsp_valid && lat < 40) begin
      if (cell_we != '0) we = cell_we;
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) chk("rsp_wait_timeout", rsp_valid, 1);
    st = rsp_status; val = rsp_value;
    repeat (hold) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic set_cell(input int i, input logic vld, input logic [63:0] k, input logic [63:0] v);
    tb_valid[i] = vld; tb_key[i] = k; tb_val[i] = v;
  endtask

  task automatic clear_cells();
    for (int i = 0; i < N; i++) set_cell(i, 1'b0, '0, '0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int           lat;
    logic [1:0]   st;
    logic [63:0]  val;
    logic [N-1:0] we;
    int           early;
    logic [N-1:0] seen;
`ifdef CACHE_CTRL_EARLY_EXIT_EN
    early = 1;
`else
    early = 0;
`endif
    clear_cells();
    repeat (3) @(negedge clk);
    chk("reset_cell_we", cell_we, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_status", rsp_status, 0);
    chk("reset_rsp_value", rsp_value, 0);
    chk("reset_ttl_wr", cell_ttl_wr, 0);
    chk("reset_busy", busy, 0);
    #2 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("post_reset_cmd_ready", cmd_ready, 1);

    // SET into an empty array lands in cell 0
    run(2'd1, 64'hA5, 64'h1234, 32'd10, 0, lat, st, val, we);
    chk("set_empty_lat", lat, 6);
    chk("set_empty_we", we, 4'b0001);
    chk("set_empty_st", st, 0);

    set_cell(2, 1'b1, 64'hA5, 64'h77);
    run(2'd0, 64'hA5, 0, 0, 0, lat, st, val, we);
    chk("get_hit_lat", lat, early ? 4 : 5);
    chk("get_hit_st", st, 0);
    chk("get_hit_val", val, 64'h77);
    run(2'd0, 64'hB0, 0, 0, 0, lat, st, val, we);
    chk("get_miss_lat", lat, 5);
    chk("get_miss_st", st, 1);
    chk("get_miss_val", val, 0);

    for (int i = 0; i < N; i++) set_cell(i, 1'b1, 64'(16 * (i + 1)), 64'(256 * (i + 1)));
    run(2'd1, 64'h50, 64'hDEAD, 32'd5, 0, lat, st, val, we);
    chk("set_full_lat", lat, 5);
    chk("set_full_st", st, 2);
    chk("set_full_we", we, 0);
    run(2'd1, 64'h40, 64'h999, 32'd20, 0, lat, st, val, we);
    chk("set_refresh_we", we, 4'b1000);
    chk("set_refresh_lat", lat, 6);

    run(2'd2, 64'h20, 0, 0, 0, lat, st, val, we);
    chk("del_hit_we", we, 4'b0010);
    chk("del_hit_lat", lat, early ? 4 : 6);
    chk("del_hit_st", st, 0);
    run(2'd2, 64'h99, 0, 0, 0, lat, st, val, we);
    chk("del_miss_st", st, 1);
    chk("del_miss_lat", lat, 5);
    run(2'd3, 64'h10, 0, 0, 0, lat, st, val, we);
    chk("err_op_st", st, 3);
    chk("err_op_lat", lat, 1);
    run(2'd1, 64'h10, 64'h1, 32'd0, 0, lat, st, val, we);
    chk("err_ttl_st", st, 3);
    chk("err_ttl_lat", lat, 1);

    // Response held off for 5 cycles
    run(2'd0, 64'h30, 0, 0, 5, lat, st, val, we);
    chk("hold_st", st, 0);
    chk("hold_val", val, 64'h300);

    // Duplicate keys pick the lowest index; a match beats a lower free slot
    set_cell(0, 1'b0, 64'h0, 64'h0);
    set_cell(1, 1'b1, 64'h55, 64'hAAA);
    set_cell(2, 1'b0, 64'h0, 64'h0);
    set_cell(3, 1'b1, 64'h55, 64'hBBB);
    run(2'd0, 64'h55, 0, 0, 0, lat, st, val, we);
    chk("dup_get_val", val, 64'hAAA);
    set_cell(1, 1'b1, 64'h11, 64'hAAA);
    run(2'd1, 64'h55, 64'hCCC, 32'd7, 0, lat, st, val, we);
    chk("match_over_free_we", we, 4'b1000);

    // Reset in the middle of a scan drops the command
    clear_cells();
    @(negedge clk);
    cmd_op = 2'd1; cmd_key = 64'hA5; cmd_value = 64'h1; cmd_ttl = 32'd3; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    seen = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen = seen | cell_we;
      if (rsp_valid) seen[0] = 1'b1;
    end
    chk("rst_drop_activity", seen, 0);
    chk("rst_drop_cmd_ready", cmd_ready, 1);

    set_cell(0, 1'b1, 64'h77, 64'h5A5A);
    run(2'd0, 64'h77, 0, 0, 0, lat, st, val, we);
    chk("get_cell0_lat", lat, early ? 2 : 5);
    chk("get_cell0_val", val, 64'h5A5A);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
